// File: rtl/por_rst_seq.sv
// por_rst_seq: debounces pwup_filt, releases domain resets in order, re-asserts them on brown-out or sw request.
// Latency: pwup_filt fall to rstb=0 in 3 cycles, sw_rst_req in 1; no backpressure. POR_RST_SEQ_BOD_CNT_EN adds bod_cnt.
module por_rst_seq #(
  parameter int NUM_DOMAINS = 3,
  parameter int STAGE_DLY   = 16,
  parameter int DEB_CYC     = 8,
  parameter int CNT_W       = 8
) (
  input  logic                   osc_ck,
  input  logic                   por,
  input  logic                   pwup_filt,
  input  logic                   sw_rst_req,
  input  logic                   bod_clr,
  output logic [NUM_DOMAINS-1:0] rstb,
  output logic                   rst_done,
  output logic [1:0]             rst_cause,
  output logic                   bod_event,
  output logic [CNT_W-1:0]       bod_cnt,
  output logic                   osc_keep
);
  localparam int STG_W = $clog2(STAGE_DLY);
  localparam int DEB_W = $clog2(DEB_CYC + 1);
  localparam int IDX_W = (NUM_DOMAINS > 1) ? $clog2(NUM_DOMAINS) : 1;
  localparam logic [STG_W-1:0] STG_LAST = STG_W'(STAGE_DLY - 1);
  localparam logic [DEB_W-1:0] DEB_MAX  = DEB_W'(DEB_CYC);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DOMAINS - 1);
  localparam logic [1:0] CAUSE_POR = 2'b00;
  localparam logic [1:0] CAUSE_BOD = 2'b01;
  localparam logic [1:0] CAUSE_SW  = 2'b10;

  typedef enum logic [1:0] {WAIT_PWR, RELEASE, RUN, SW_RST} state_t;

  logic                   sync1_q, sync1_d, sync2_q, sync2_d;
  logic [DEB_W-1:0]       deb_q, deb_d;
  logic                   pg;
  state_t                 state_q, state_d;
  logic [STG_W-1:0]       stg_q, stg_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic [NUM_DOMAINS-1:0] rstb_q, rstb_d;
  logic                   done_q, done_d;
  logic [1:0]             cause_q, cause_d;
  logic                   bod_event_q, bod_event_d;
  logic                   osc_keep_q, osc_keep_d;
  logic                   brown_out;

  // pg drops on the very first synchronized-low sample, not a cycle later.
  assign pg = sync2_q && (deb_q == DEB_MAX);

  always_comb begin
    sync1_d = pwup_filt;
    sync2_d = sync1_q;
    deb_d   = deb_q;
    if (!sync2_q)
      deb_d = '0;
    else if (deb_q != DEB_MAX)
      deb_d = deb_q + DEB_W'(1);
  end

  always_comb begin
    state_d     = state_q;
    stg_d       = stg_q;
    idx_d       = idx_q;
    rstb_d      = rstb_q;
    done_d      = done_q;
    cause_d     = cause_q;
    bod_event_d = 1'b0;
    brown_out   = 1'b0;
    case (state_q)
      WAIT_PWR: begin
        rstb_d = '0;
        done_d = 1'b0;
        if (pg) begin
          state_d = RELEASE;
          stg_d   = '0;
          idx_d   = '0;
        end
      end
      RELEASE: begin
        if (!pg) begin
          brown_out = 1'b1;
        end else if (stg_q == STG_LAST) begin
          stg_d         = '0;
          rstb_d[idx_q] = 1'b1;
          if (idx_q == IDX_LAST) begin
            done_d  = 1'b1;
            state_d = RUN;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end else begin
          stg_d = stg_q + STG_W'(1);
        end
      end
      RUN: begin
        if (!pg) begin
          brown_out = 1'b1;
        end else if (sw_rst_req) begin
          state_d = SW_RST;
          rstb_d  = '0;
          done_d  = 1'b0;
          cause_d = CAUSE_SW;
          stg_d   = '0;
        end
      end
      SW_RST: begin
        if (!pg) begin
          brown_out = 1'b1;
        end else if (stg_q == STG_LAST) begin
          state_d = RELEASE;
          stg_d   = '0;
          idx_d   = '0;
        end else begin
          stg_d = stg_q + STG_W'(1);
        end
      end
      default: state_d = WAIT_PWR;
    endcase
    if (brown_out) begin
      state_d     = WAIT_PWR;
      rstb_d      = '0;
      done_d      = 1'b0;
      cause_d     = CAUSE_BOD;
      bod_event_d = 1'b1;
    end
    osc_keep_d = (state_d != RUN);
  end

  always_ff @(posedge osc_ck) begin
    if (por) begin
      sync1_q     <= 1'b0;
      sync2_q     <= 1'b0;
      deb_q       <= '0;
      state_q     <= WAIT_PWR;
      stg_q       <= '0;
      idx_q       <= '0;
      rstb_q      <= '0;
      done_q      <= 1'b0;
      cause_q     <= CAUSE_POR;
      bod_event_q <= 1'b0;
      osc_keep_q  <= 1'b1;
    end else begin
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
      deb_q       <= deb_d;
      state_q     <= state_d;
      stg_q       <= stg_d;
      idx_q       <= idx_d;
      rstb_q      <= rstb_d;
      done_q      <= done_d;
      cause_q     <= cause_d;
      bod_event_q <= bod_event_d;
      osc_keep_q  <= osc_keep_d;
    end
  end

  assign rstb      = rstb_q;
  assign rst_done  = done_q;
  assign rst_cause = cause_q;
  assign bod_event = bod_event_q;
  assign osc_keep  = osc_keep_q;

`ifdef POR_RST_SEQ_BOD_CNT_EN
  logic [CNT_W-1:0] bod_cnt_q, bod_cnt_d;

  // A clear coinciding with a brown-out keeps that brown-out counted.
  always_comb begin
    bod_cnt_d = bod_cnt_q;
    if (brown_out)
      bod_cnt_d = bod_clr ? CNT_W'(1) : ((&bod_cnt_q) ? bod_cnt_q : bod_cnt_q + CNT_W'(1));
    else if (bod_clr)
      bod_cnt_d = '0;
  end

  always_ff @(posedge osc_ck) begin
    if (por) bod_cnt_q <= '0;
    else     bod_cnt_q <= bod_cnt_d;
  end

  assign bod_cnt = bod_cnt_q;
`else
  logic unused_bod_clr;
  assign unused_bod_clr = bod_clr;
  assign bod_cnt        = '0;
`endif

endmodule

// File: doc/por_rst_seq.md
# por_rst_seq

Digital reset sequencer that consumes the power-on-reset block's outputs and turns them into ordered, per-domain reset releases for the rest of the chip. It runs in the dvdd domain, clocked by the POR RC oscillator. It debounces `pwup_filt`, releases domain resets one at a time after power is good, re-asserts them on brown-out or software request, and records the reset cause. It also holds the RC oscillator on until sequencing has completed.

## Interface
Parameters:
- `NUM_DOMAINS`, 3: number of sequenced reset outputs (≥1).
- `STAGE_DLY`, 16: `osc_ck` cycles between consecutive releases; also the minimum software-reset hold time (≥2).
- `DEB_CYC`, 8: consecutive synchronized-high samples of `pwup_filt` required for power-good (≥1).
- `CNT_W`, 8: brown-out counter width.

Ports:
- `osc_ck`  in  1  block clock (~656 kHz POR RC oscillator).
- `por`  in  1  reset; synchronous, active-high.
- `pwup_filt`  in  1  asynchronous power-above-trip indication.
- `sw_rst_req`  in  1  single-cycle software reset request.
- `bod_clr`  in  1  clears `bod_cnt`.
- `rstb`  out  NUM_DOMAINS  active-low domain resets; bit 0 is released first.
- `rst_done`  out  1  all domains released.
- `rst_cause`  out  2  00 = POR, 01 = brown-out, 10 = software.
- `bod_event`  out  1  one-cycle pulse per brown-out.
- `bod_cnt`  out  CNT_W  saturating brown-out count.
- `osc_keep`  out  1  drives `force_ena_rc_osc`.

## Operation
- **Power-good path.** `pwup_filt` passes through a 2-flop synchronizer into a debounce counter.
  - `pg` sets when the counter reaches `DEB_CYC`.
  - `pg` clears on the first synchronized-low sample, which also zeroes the counter.
- **States:** `WAIT_PWR`, `RELEASE`, `RUN`, `SW_RST`.
  - `WAIT_PWR`: all `rstb` = 0. Moves to `RELEASE` on `pg`.
  - `RELEASE`: a stage counter counts `STAGE_DLY` cycles, then sets `rstb[i]`, increments `i` and restarts. The edge that sets `rstb[NUM_DOMAINS-1]` also sets `rst_done` and enters `RUN`.
  - `RUN`: `rst_done` = 1.
    - `sw_rst_req` → `SW_RST`.
    - Loss of `pg` → `WAIT_PWR`.
  - `SW_RST`: all `rstb` = 0 and `rst_done` = 0 for `STAGE_DLY` cycles, then `RELEASE` if `pg`, else `WAIT_PWR`.
- **Brown-out.** Loss of `pg` in `RELEASE`, `RUN` or `SW_RST`:
  - next edge: `rstb` = 0, `rst_done` = 0, state `WAIT_PWR`;
  - `rst_cause` = 01, `bod_event` pulses for one cycle, `bod_cnt` increments.
  - Loss of `pg` while already in `WAIT_PWR` is not a brown-out.
- **Software reset.** Entering `SW_RST` sets `rst_cause` = 10. `sw_rst_req` is ignored outside `RUN`.
- **`bod_cnt`.** Saturates at all-ones. `bod_clr` zeroes it. If `bod_clr` and a brown-out occur in the same cycle, `bod_cnt` = 1.
- **`osc_keep`.** 1 in every state except `RUN`.

## Timing
- Reset values while `por` = 1:
  - `rstb` = 0, `rst_done` = 0, `rst_cause` = 00, `bod_event` = 0, `bod_cnt` = 0, `osc_keep` = 1;
  - synchronizer and all counters = 0; state `WAIT_PWR`.
- `pwup_filt` rise to `pg`: `DEB_CYC`+2 cycles, with `pwup_filt` held high.
- `pg` to `RELEASE`: 1 cycle. `rstb[i]` rises (i+1)·`STAGE_DLY` cycles after entering `RELEASE`.
- `pwup_filt` fall to `rstb` = 0: 3 cycles (2 sync + 1 state).
- `sw_rst_req` to `rstb` = 0: 1 cycle.
- Priority in one cycle: `por` > brown-out > `sw_rst_req`.
- `por` asserted mid-sequence: all outputs take reset values on the next edge. The sequence restarts from `WAIT_PWR`.

## Configuration
- `POR_RST_SEQ_BOD_CNT_EN`
  - Defined: the `bod_cnt` register, saturation and `bod_clr` logic are present.
  - Undefined: `bod_cnt` is tied to 0 and `bod_clr` is ignored. `bod_event` and `rst_cause` behave unchanged.

## Test plan
Defaults throughout (`NUM_DOMAINS`=3, `STAGE_DLY`=16, `DEB_CYC`=8, `CNT_W`=8).

1. `por` pulsed for 4 cycles, then `pwup_filt` = 1 → `pg` after 10 cycles; `rstb` = 001/011/111 at 16/32/48 cycles after `RELEASE` entry; `rst_done` = 1 and `osc_keep` = 0 at 48; `rst_cause` = 00.
2. `pwup_filt` high for 5 cycles then low, repeated → `pg` never sets; `rstb` stays 000.
3. In `RUN`, `pwup_filt` low for 3 cycles → `rstb` = 000 within 3 cycles; `bod_event` pulses once; `bod_cnt` = 1; `rst_cause` = 01. Once `pwup_filt` returns high, the full 48-cycle release sequence reruns.
4. In `RUN`, `sw_rst_req` for 1 cycle → `rstb` = 000 next edge, held 16 cycles; `rst_cause` = 10; then normal release. A `sw_rst_req` during `RELEASE` has no effect.
5. 256 brown-outs → `bod_cnt` = 255. `bod_clr` coincident with a brown-out → `bod_cnt` = 1. With the macro undefined → `bod_cnt` = 0 throughout.
6. `por` asserted when `rstb` = 011 → next edge `rstb` = 000, `rst_cause` = 00, `osc_keep` = 1.
